// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default timing, the default colour/coordinate widths,
// the flag bundle that travels down the latency-compensation pipe, and the
// h/v total helper functions.
package vga_timing_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;
    localparam int unsigned DefColorW  = 4;
    localparam int unsigned DefCoordW  = 10;

    // Raw per-pixel decode, delayed as one bundle so all flags stay aligned.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
    } flags_t;

    localparam int unsigned FlagW = $bits(flags_t);

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bus of the VGA timing generator.
// master: the generator (takes EN/CSEL, drives coordinates, syncs, DE, RGB, strobes).
// slave : the colour source / board side (drives EN/CSEL, observes everything else).
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int unsigned COLOR_W = DefColorW,
    parameter int unsigned COORD_W = DefCoordW
);
    logic                   EN;
    logic [3*COLOR_W-1:0]   CSEL;
    logic [COORD_W-1:0]     HCOORD;
    logic [COORD_W-1:0]     VCOORD;
    logic                   HSYNC;
    logic                   VSYNC;
    logic                   DE;
    logic [COLOR_W-1:0]     RED;
    logic [COLOR_W-1:0]     GREEN;
    logic [COLOR_W-1:0]     BLUE;
    logic                   LINE_START;
    logic                   FRAME_START;

    modport master (
        input  EN, CSEL,
        output HCOORD, VCOORD, HSYNC, VSYNC, DE, RED, GREEN, BLUE, LINE_START, FRAME_START
    );

    modport slave (
        output EN, CSEL,
        input  HCOORD, VCOORD, HSYNC, VSYNC, DE, RED, GREEN, BLUE, LINE_START, FRAME_START
    );
endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH enable-qualified shift register with asynchronous clear.
// Ports: CLK clock, aclr_i async active-high clear, en shift enable,
//        din input word, dout word delayed by DEPTH enabled cycles.
// DEPTH = 0 degenerates to a combinational pass-through.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLK,
    input  logic             aclr_i,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{CLK, aclr_i, en};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge CLK or posedge aclr_i) begin
            if (aclr_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (en) begin
                stage_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator and pixel output stage.
// Ports: CLK clock; aclr_i async active-high reset;
//        bus (master): EN pixel enable, CSEL {R,G,B} in; HCOORD/VCOORD request
//        coordinates, HSYNC/VSYNC/DE/RED/GREEN/BLUE pins, LINE_START/FRAME_START out.
// Coordinates leave PIX_LAT+1 enabled cycles ahead of the pins so the upstream
// colour lookup can take PIX_LAT cycles; sync/DE/strobe flags are delayed to match.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = DefColorW,
    parameter int unsigned COORD_W  = DefCoordW,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic             CLK,
    input  logic             aclr_i,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (PIX_LAT > 3) begin : g_bad_pix_lat
        $error("vga_timing_gen: PIX_LAT must be in 0..3");
    end
    if ((((H_TOTAL - 1) >> COORD_W) != 0) || (((V_TOTAL - 1) >> COORD_W) != 0))
    begin : g_bad_coord_w
        $error("vga_timing_gen: COORD_W too small for H_TOTAL-1 / V_TOTAL-1");
    end
    if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end

    localparam logic [COORD_W-1:0] HLast    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] VLast    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] HActive  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VActive  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HsFirst  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HsLast   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VsFirst  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VsLast   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Raster counters.
    logic [COORD_W-1:0] h_q, v_q;

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            h_q <= '0;
            v_q <= '0;
        end else if (bus.EN) begin
            if (h_q == HLast) begin
                h_q <= '0;
                v_q <= (v_q == VLast) ? '0 : v_q + COORD_W'(1);
            end else begin
                h_q <= h_q + COORD_W'(1);
            end
        end
    end

    assign bus.HCOORD = h_q;
    assign bus.VCOORD = v_q;

    // Decode of the coordinate currently being requested.
    flags_t raw, dly;

    always_comb begin
        raw    = '0;
        raw.hs = (h_q >= HsFirst) && (h_q <= HsLast);
        raw.vs = (v_q >= VsFirst) && (v_q <= VsLast);
        raw.de = (h_q < HActive) && (v_q < VActive);
        raw.ls = (h_q == '0);
        raw.fs = (h_q == '0) && (v_q == '0);
    end

    vga_delay_line #(
        .WIDTH (FlagW),
        .DEPTH (PIX_LAT)
    ) u_flag_dly (
        .CLK    (CLK),
        .aclr_i (aclr_i),
        .en     (bus.EN),
        .din    (raw),
        .dout   (dly)
    );

    // Output register: CSEL and the delayed flags belong to the same pixel here.
    logic                 hsync_q, vsync_q, de_q, ls_q, fs_q;
    logic [3*COLOR_W-1:0] rgb_q;

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (bus.EN) begin
            hsync_q <= dly.hs ? HS_POL : ~HS_POL;
            vsync_q <= dly.vs ? VS_POL : ~VS_POL;
            de_q    <= dly.de;
            rgb_q   <= dly.de ? bus.CSEL : '0;
            ls_q    <= dly.ls;
            fs_q    <= dly.fs;
        end
    end

    assign bus.HSYNC = hsync_q;
    assign bus.VSYNC = vsync_q;
    assign bus.DE    = de_q;
    assign bus.RED   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.GREEN = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.BLUE  = rgb_q[COLOR_W-1:0];

    // Column-0 pixel can sit on the pins for several CLKs when EN is sparse;
    // gating with EN leaves exactly one CLK per presented pixel.
    assign bus.LINE_START  = ls_q & bus.EN;
    assign bus.FRAME_START = fs_q & bus.EN;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic CLK = 1'b0;
    logic aclr_i;
    always #5 CLK = ~CLK;

    localparam int NCyc  = 6000;
    localparam int RstAt = 5000;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, lat;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [10:0] hco;
        logic [10:0] vco;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        ls;
        logic        fs;
    } obs_t;

    cfg_t            cfg [3];
    int unsigned     k [3];
    logic [2:0]      en;
    logic [7:0]      salt;
    int              n_checks = 0;
    int              n_fail   = 0;

    vga_timing_gen_if #(.COLOR_W(4), .COORD_W(10)) bus_a ();
    vga_timing_gen_if #(.COLOR_W(4), .COORD_W(5))  bus_b ();
    vga_timing_gen_if #(.COLOR_W(4), .COORD_W(11)) bus_c ();

    vga_timing_gen #(.PIX_LAT(1)) dut_a (.CLK(CLK), .aclr_i(aclr_i), .bus(bus_a));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(4), .COORD_W(5), .PIX_LAT(3)
    ) dut_b (.CLK(CLK), .aclr_i(aclr_i), .bus(bus_b));

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .COORD_W(11), .PIX_LAT(0)
    ) dut_c (.CLK(CLK), .aclr_i(aclr_i), .bus(bus_c));

    // Position of the n-th issued coordinate in raster order.
    function automatic void coord(input cfg_t c, input longint n, output int h, output int v);
        longint ht, vt;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        h  = int'(n % ht);
        v  = int'((n / ht) % vt);
    endfunction

    function automatic logic [11:0] pix(input int h, input int v);
        return {4'(h) ^ salt[3:0], 4'(v), salt[7:4]};
    endfunction

    // Colour source: answers for the coordinate issued PIX_LAT enabled cycles ago.
    function automatic logic [11:0] csel_for(input cfg_t c, input int unsigned kk);
        int h, v;
        if (int'(kk) < c.lat) return 12'($urandom);
        coord(c, longint'(kk) - c.lat, h, v);
        return pix(h, v);
    endfunction

    // Expected observables after kk enabled edges since reset; pins show the
    // pixel issued PIX_LAT+1 enabled cycles earlier, reset values before that.
    function automatic obs_t model(input cfg_t c, input int unsigned kk, input bit e);
        obs_t        x;
        int          h, v, m;
        logic [11:0] p;
        x = '0;
        coord(c, longint'(kk), h, v);
        x.hco   = 11'(h);
        x.vco   = 11'(v);
        x.hsync = ~c.hpol;
        x.vsync = ~c.vpol;
        m = int'(kk) - 1 - c.lat;
        if (m >= 0) begin
            coord(c, longint'(m), h, v);
            if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) x.hsync = c.hpol;
            if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) x.vsync = c.vpol;
            x.de = (h < c.ha) && (v < c.va);
            if (x.de) begin
                p   = pix(h, v);
                x.r = p[11:8];
                x.g = p[7:4];
                x.b = p[3:0];
            end
            x.ls = e && (h == 0);
            x.fs = e && (h == 0) && (v == 0);
        end
        return x;
    endfunction

    function automatic obs_t obs_a();
        return {11'(bus_a.HCOORD), 11'(bus_a.VCOORD), bus_a.HSYNC, bus_a.VSYNC, bus_a.DE,
                bus_a.RED, bus_a.GREEN, bus_a.BLUE, bus_a.LINE_START, bus_a.FRAME_START};
    endfunction

    function automatic obs_t obs_b();
        return {11'(bus_b.HCOORD), 11'(bus_b.VCOORD), bus_b.HSYNC, bus_b.VSYNC, bus_b.DE,
                bus_b.RED, bus_b.GREEN, bus_b.BLUE, bus_b.LINE_START, bus_b.FRAME_START};
    endfunction

    function automatic obs_t obs_c();
        return {bus_c.HCOORD, bus_c.VCOORD, bus_c.HSYNC, bus_c.VSYNC, bus_c.DE,
                bus_c.RED, bus_c.GREEN, bus_c.BLUE, bus_c.LINE_START, bus_c.FRAME_START};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string id, input obs_t e, input obs_t g);
        check({id, " hcoord"},  64'(g.hco), 64'(e.hco));
        check({id, " vcoord"},  64'(g.vco), 64'(e.vco));
        check({id, " syncs"},   64'({g.hsync, g.vsync}), 64'({e.hsync, e.vsync}));
        check({id, " de"},      64'(g.de), 64'(e.de));
        check({id, " rgb"},     64'({g.r, g.g, g.b}), 64'({e.r, e.g, e.b}));
        check({id, " strobes"}, 64'({g.ls, g.fs}), 64'({e.ls, e.fs}));
    endtask

    task automatic check_all();
        compare("a", model(cfg[0], k[0], en[0]), obs_a());
        compare("b", model(cfg[1], k[1], en[1]), obs_b());
        compare("c", model(cfg[2], k[2], en[2]), obs_c());
    endtask

    task automatic drive_inputs();
        bus_a.EN   = en[0];
        bus_b.EN   = en[1];
        bus_c.EN   = en[2];
        bus_a.CSEL = csel_for(cfg[0], k[0]);
        bus_b.CSEL = csel_for(cfg[1], k[1]);
        bus_c.CSEL = csel_for(cfg[2], k[2]);
    endtask

    // Hand-derived values that pin the model itself.
    task automatic check_literals();
        if (k[0] == 1)   check("a lit fs k1", 64'(bus_a.FRAME_START), 64'd0);
        if (k[0] == 2)   check("a lit fs k2", 64'({bus_a.LINE_START, bus_a.FRAME_START}), 64'd3);
        if (k[0] == 2)   check("a lit de k2", 64'(bus_a.DE), 64'd1);
        if (k[0] == 641) check("a lit de h639", 64'(bus_a.DE), 64'd1);
        if (k[0] == 642) check("a lit de h640", 64'({bus_a.DE, bus_a.RED}), 64'd0);
        if (k[0] == 657) check("a lit hsync h655", 64'(bus_a.HSYNC), 64'd1);
        if (k[0] == 658) check("a lit hsync h656", 64'(bus_a.HSYNC), 64'd0);
        if (k[0] == 753) check("a lit hsync h751", 64'(bus_a.HSYNC), 64'd0);
        if (k[0] == 754) check("a lit hsync h752", 64'(bus_a.HSYNC), 64'd1);
        if (k[0] == 799) check("a lit hcoord 799", 64'(bus_a.HCOORD), 64'd799);
        if (k[0] == 800) check("a lit wrap", 64'({bus_a.HCOORD, bus_a.VCOORD}), 64'd1);
        if (k[2] == 840) check("c lit hsync h839", 64'(bus_c.HSYNC), 64'd0);
        if (k[2] == 841) check("c lit hsync h840", 64'(bus_c.HSYNC), 64'd1);
        if (k[2] == 968) check("c lit hsync h967", 64'(bus_c.HSYNC), 64'd1);
        if (k[2] == 969) check("c lit hsync h968", 64'(bus_c.HSYNC), 64'd0);
        if (k[2] == 1055) check("c lit hcoord 1055", 64'(bus_c.HCOORD), 64'd1055);
        if (k[2] == 1056) check("c lit wrap", 64'({bus_c.HCOORD, bus_c.VCOORD}), 64'd1);
        if (k[2] == 1 && en[2]) check("c lit fs k1", 64'(bus_c.FRAME_START), 64'd1);
    endtask

    initial begin
        cfg[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:1,
                   hpol:1'b0, vpol:1'b0};
        cfg[1] = '{ha:16, hf:2, hs:3, hb:3, va:6, vf:1, vs:2, vb:1, lat:3,
                   hpol:1'b0, vpol:1'b1};
        cfg[2] = '{ha:800, hf:40, hs:128, hb:88, va:600, vf:1, vs:4, vb:23, lat:0,
                   hpol:1'b1, vpol:1'b1};
        salt   = 8'($urandom);
        k      = '{0, 0, 0};
        en     = '0;
        aclr_i = 1'b1;
        drive_inputs();

        for (int cyc = 0; cyc < NCyc; cyc++) begin
            @(posedge CLK);
            if (!aclr_i) begin
                for (int i = 0; i < 3; i++) if (en[i]) k[i]++;
            end
            #1;
            if (cyc == 3 || cyc == RstAt + 3) aclr_i = 1'b0;
            en[0] = 1'b1;
            en[1] = ($urandom_range(0, 3) != 0);
            en[2] = (cyc % 4 == 0);
            drive_inputs();
            if (cyc == RstAt) begin
                // Asynchronous reset mid-frame: pins must drop without a clock edge.
                #1 aclr_i = 1'b1;
                k = '{0, 0, 0};
                #1 check_all();
                check("a lit async rst", 64'({bus_a.HCOORD, bus_a.HSYNC, bus_a.DE}), 64'd2);
            end
            if (cyc == 1) begin
                check("rst lit hsync a/c", 64'({bus_a.HSYNC, bus_c.HSYNC}), 64'd2);
                check("rst lit vsync b/c", 64'({bus_b.VSYNC, bus_c.VSYNC}), 64'd0);
            end
            @(negedge CLK);
            check_all();
            if (!aclr_i) check_literals();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
